// File: rtl/pcg_if.sv
// Shared types for the PC generator and a generic AXI-Stream interface.
// The fetch beat carries the PC plus the prediction made for it.
package pcg_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [1:0]      rsvd;
  } pcgif_tdata_t;
endpackage

interface axis_if #(parameter int TDATA_WIDTH = 8);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/pcg.sv
// Program Counter Generator: sequential fetch PC stream with redirect, halt and
// an optional direct-mapped BTB enabled by the PCG_BTB_EN macro.
module pcg
  import pcg_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  axis_if.m               pcgif_axis_if,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            invalidate,
  input  logic            halt_req,
  output logic            halted
`ifdef PCG_BTB_EN
  ,
  input  logic            btb_upd_valid,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_target
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic            halted_q;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            tvalid;
  logic            hs;
  pcgif_tdata_t    td;
  logic            unused_bits;

  assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign seq_pc   = pc_q + XLEN'(4);

  // A redirect masks tvalid so it can never coincide with a handshake.
  assign tvalid     = (state == RUN) && !redirect_valid;
  assign hs         = tvalid && pcgif_axis_if.tready;
  assign invalidate = redirect_valid && !rst;
  assign halted     = halted_q;

`ifdef PCG_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_vld;
  logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];
  logic [IDX_W-1:0]       lk_idx, up_idx;
  logic                   btb_hit;

  assign lk_idx  = pc_q[2 +: IDX_W];
  assign up_idx  = btb_upd_pc[2 +: IDX_W];
  assign btb_hit = btb_vld[lk_idx] && (btb_tag[lk_idx] == pc_q[XLEN-1 -: TAG_W]);

  assign pred_taken  = btb_hit;
  assign pred_target = btb_hit ? btb_tgt[lk_idx] : seq_pc;
  assign unused_bits = ^{redirect_pc[1:0], btb_upd_pc[1:0]};

  // Updates land at the edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_vld <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
      end
    end else if (btb_upd_valid) begin
      btb_vld[up_idx] <= 1'b1;
      btb_tag[up_idx] <= btb_upd_pc[XLEN-1 -: TAG_W];
      btb_tgt[up_idx] <= btb_upd_target;
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = seq_pc;
  assign unused_bits = ^redirect_pc[1:0];
`endif

  assign next_pc = pred_taken ? pred_target : seq_pc;

  always_comb begin
    td             = '0;
    td.pc          = pc_q;
    td.pred_taken  = pred_taken;
    td.pred_target = pred_target;
  end

  assign pcgif_axis_if.tvalid = tvalid;
  assign pcgif_axis_if.tdata  = td;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc_q     <= RESET_VECTOR;
      halted_q <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          if (redirect_valid) pc_q <= redir_pc;
        end
        RUN: begin
          if (redirect_valid) pc_q <= redir_pc;
          else if (hs)        pc_q <= next_pc;
          // Halt only once no beat is left hanging on the bus.
          if (halt_req && (!tvalid || hs)) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          if (redirect_valid) pc_q <= redir_pc;
          if (!halt_req) begin
            state    <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcg.sv
// Self-checking bench for pcg: directed steps followed by a randomized phase,
// all compared against a cycle-level behavioural model of the fetch PC stream.
module tb_pcg;
  import pcg_pkg::*;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        invalidate;
  logic        halt_req;
  logic        halted;
`ifdef PCG_BTB_EN
  logic        btb_upd_valid;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_target;
`endif

  axis_if #(.TDATA_WIDTH($bits(pcgif_tdata_t))) axis ();
  pcgif_tdata_t td;
  assign td = axis.tdata;

  pcg #(.RESET_VECTOR(RV), .BTB_ENTRIES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .pcgif_axis_if  (axis),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .invalidate     (invalidate),
    .halt_req       (halt_req),
    .halted         (halted)
`ifdef PCG_BTB_EN
    ,
    .btb_upd_valid  (btb_upd_valid),
    .btb_upd_pc     (btb_upd_pc),
    .btb_upd_target (btb_upd_target)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: booting flag, halted flag and the PC the stream should present.
  bit          m_boot;
  bit          m_halt;
  logic [31:0] m_pc;
`ifdef PCG_BTB_EN
  bit          m_bv;
  logic [31:0] m_bpc, m_btgt;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_halt = 1'b0;
    m_pc   = RV;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic hr, input logic tr);
    bit          exp_tv, acc, hit;
    logic [31:0] tgt;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    axis.tready    = tr;
    #1;
    hit = 1'b0;
    tgt = m_pc + 32'd4;
`ifdef PCG_BTB_EN
    if (m_bv && m_pc == m_bpc) begin
      hit = 1'b1;
      tgt = m_btgt;
    end
`endif
    exp_tv = !m_boot && !m_halt && !rv;
    chk("tvalid",      {31'd0, axis.tvalid}, {31'd0, exp_tv});
    chk("invalidate",  {31'd0, invalidate},  {31'd0, rv});
    chk("halted",      {31'd0, halted},      {31'd0, m_halt});
    chk("pc",          td.pc,                m_pc);
    chk("pred_taken",  {31'd0, td.pred_taken}, {31'd0, hit});
    chk("pred_target", td.pred_target,       tgt);
    @(posedge clk);
    if (m_boot) begin
      m_boot = 1'b0;
      if (rv) m_pc = {rpc[31:2], 2'b00};
    end else begin
      acc = exp_tv && tr;
      if (rv)       m_pc = {rpc[31:2], 2'b00};
      else if (acc) m_pc = tgt;
      if (m_halt)              m_halt = hr;
      else if (hr && (rv || acc)) m_halt = 1'b1;
    end
`ifdef PCG_BTB_EN
    if (btb_upd_valid) begin
      m_bv   = 1'b1;
      m_bpc  = btb_upd_pc;
      m_btgt = btb_upd_target;
    end
`endif
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    axis.tready    = 1'b0;
`ifdef PCG_BTB_EN
    btb_upd_valid  = 1'b0;
    btb_upd_pc     = '0;
    btb_upd_target = '0;
    m_bv           = 1'b0;
    m_bpc          = '0;
    m_btgt         = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid",     {31'd0, axis.tvalid}, 32'd0);
    chk("rst_pc",         td.pc, RV);
    chk("rst_halted",     {31'd0, halted}, 32'd0);
    chk("rst_invalidate", {31'd0, invalidate}, 32'd0);
    rst = 1'b0;

    // Boot and three sequential beats.
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);
    // Backpressure: beat held for five cycles.
    repeat (5) step(1'b0, '0, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1);
    // Redirect with a pending beat; low bits dropped.
    step(1'b1, 32'h0000_1003, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1);
    // Halt requested while a beat is stalled.
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    repeat (2) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1);
    // Redirect while halted, then a held redirect.
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_4000, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_5000, 1'b0, 1'b1);
    step(1'b1, 32'h0000_6002, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    // Wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(7) == 0), $urandom, ($urandom_range(5) == 0), $urandom_range(1) == 1);
    end

    // Reset mid-stream takes effect without waiting for a clock edge.
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    chk("mid_rst_pc",     td.pc, RV);
    chk("mid_rst_halted", {31'd0, halted}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("mid_rst_hold_tvalid", {31'd0, axis.tvalid}, 32'd0);
    rst = 1'b0;
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);

`ifdef PCG_BTB_EN
    btb_upd_valid  = 1'b1;
    btb_upd_pc     = 32'h0000_0100;
    btb_upd_target = 32'h0000_0200;
    step(1'b0, '0, 1'b0, 1'b0);
    btb_upd_valid  = 1'b0;
    step(1'b1, 32'h0000_0100, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
